// File: rtl/permute_sched_pkg.sv
// permute_sched_pkg: shared network sizing and FSM state encoding for the permutation sequencer.
package permute_sched_pkg;
    localparam int P   = 2;
    localparam int MAP = 2;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_FLUSH, S_DONE} state_t;
endpackage

// File: rtl/permute_sched_if.sv
// permute_sched_if: control handshake plus read/write address and select buses of the sequencer.
interface permute_sched_if #(
    parameter int N    = 4,
    parameter int SELW = 2,
    parameter int SW   = 3,
    parameter int AW   = 6
);
    logic            start, busy, done, rd_valid, wr_valid;
    logic [SW-1:0]   stage;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [N*SELW-1:0] sel_out_bus, sel_in_bus;
    modport master(input start, output busy, done, stage, rd_valid, rd_addr, sel_out_bus,
                   wr_valid, wr_addr, sel_in_bus);
    modport slave(output start, input busy, done, stage, rd_valid, rd_addr, sel_out_bus,
                  wr_valid, wr_addr, sel_in_bus);
endinterface

// File: rtl/permute_dly.sv
// permute_dly: LAT-deep register delay line, cleared asynchronously.
module permute_dly #(
    parameter int W   = 1,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] pipe [LAT];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    assign q = pipe[LAT-1];
endmodule

// File: rtl/permute_sched.sv
// permute_sched: stage/cycle sequencer issuing rotated gather selects and their LAT-delayed scatter twins.
module permute_sched
    import permute_sched_pkg::*;
#(
    parameter int N      = 2*P,
    parameter int SELW   = MAP,
    parameter int NSTAGE = 8,
    parameter int SW     = 3,
    parameter int AW     = 6,
    parameter int LAT    = 6
) (
    input logic clk,
    input logic rst,
    permute_sched_if.master sif
);
    localparam int GW = $clog2(LAT+1);
    localparam int W  = 1 + AW + N*SELW;
    state_t            state, nxt;
    logic [AW-1:0]     rd_addr;
    logic [SW-1:0]     stage;
    logic [GW-1:0]     gap;
    logic              rd_valid, gap_end, last_beat;
    logic [31:0]       rot;
    logic [N*SELW-1:0] sel_out;
    logic [W-1:0]      dq;
    assign gap_end   = gap == GW'(LAT-1);
    assign last_beat = rd_addr == {AW{1'b1}};
    assign rd_valid  = state == S_RUN;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = sif.start ? S_RUN : S_IDLE;
            S_RUN:   nxt = !last_beat ? S_RUN : stage == SW'(NSTAGE-1) ? S_FLUSH : S_WAIT;
            S_WAIT:  nxt = gap_end ? S_RUN : S_WAIT;
            S_FLUSH: nxt = gap_end ? S_DONE : S_FLUSH;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= S_IDLE;
            rd_addr <= '0;
            stage   <= '0;
            gap     <= '0;
        end else begin
            state   <= nxt;
            rd_addr <= rd_valid ? rd_addr + AW'(1) : '0;
            gap     <= ((state == S_WAIT || state == S_FLUSH) && !gap_end) ? gap + GW'(1) : '0;
            stage   <= nxt == S_IDLE ? '0 : (state == S_WAIT && gap_end) ? stage + SW'(1) : stage;
        end
    // Rotation is formed at 32 bits and masked so every select stays below N.
    assign rot = (32'(stage) + 32'(rd_addr)) & 32'(N-1);
    for (genvar k = 0; k < N; k++) begin : g_rot
        assign sel_out[k*SELW +: SELW] = rd_valid ? SELW'((32'(k) + rot) & 32'(N-1)) : '0;
    end
    permute_dly #(.W(W), .LAT(LAT)) u_dly (
        .clk(clk),
        .rst(rst),
        .d({rd_valid, rd_addr, sel_out}),
        .q(dq)
    );
    assign {sif.wr_valid, sif.wr_addr, sif.sel_in_bus} = dq;
    assign sif.busy        = state != S_IDLE;
    assign sif.done        = state == S_DONE;
    assign sif.stage       = stage;
    assign sif.rd_valid    = rd_valid;
    assign sif.rd_addr     = rd_addr;
    assign sif.sel_out_bus = sel_out;
endmodule

// File: tb/tb_permute_sched.sv
// tb_permute_sched: random start/reset stimulus against a cycle-schedule model and a gather/scatter loopback.
module tb_permute_sched;
    localparam int N = 4, SELW = 2, NSTAGE = 2, SW = 2, AW = 2, LAT = 3;
    localparam int CPS = 1 << AW;
    localparam int T   = NSTAGE*(CPS+LAT) + 1;

    typedef struct packed {
        logic              v;
        logic [AW-1:0]     a;
        logic [N*SELW-1:0] s;
    } beat_t;
    typedef logic [N*8-1:0] data_t;

    logic clk = 0;
    logic rst = 1;
    permute_sched_if #(.N(N), .SELW(SELW), .SW(SW), .AW(AW)) sif();
    permute_sched #(.N(N), .SELW(SELW), .NSTAGE(NSTAGE), .SW(SW), .AW(AW), .LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .sif(sif)
    );
    always #5 clk = ~clk;

    int    passed = 0, total = 0;
    bit    active = 0, did_rst = 0;
    int    rel = 0, rst_until = -1;
    beat_t hist[$];
    data_t src_q[$], port_q[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic zero_check(string pfx);
        check({pfx, "_busy"}, sif.busy, 0);
        check({pfx, "_done"}, sif.done, 0);
        check({pfx, "_stage"}, sif.stage, 0);
        check({pfx, "_rd_valid"}, sif.rd_valid, 0);
        check({pfx, "_rd_addr"}, sif.rd_addr, 0);
        check({pfx, "_sel_out"}, sif.sel_out_bus, 0);
        check({pfx, "_wr_valid"}, sif.wr_valid, 0);
        check({pfx, "_wr_addr"}, sif.wr_addr, 0);
        check({pfx, "_sel_in"}, sif.sel_in_bus, 0);
    endtask

    function automatic logic [N*SELW-1:0] gather_sel(int s, int a);
        logic [N*SELW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*SELW +: SELW] = SELW'((k + s + a) % N);
        return r;
    endfunction

    initial begin
        sif.start = 0;
        repeat (LAT) hist.push_back('0);
        #3 zero_check("reset");
        for (int cyc = 0; cyc < 800; cyc++) begin
            beat_t e;
            int    s, off;
            data_t b, p, r;
            @(negedge clk);
            off = (rel - 1) % (CPS + LAT);
            s   = (rel - 1) / (CPS + LAT);
            if (s > NSTAGE - 1) s = NSTAGE - 1;
            e.v = active && rel < T && off < CPS;
            e.a = e.v ? AW'(off) : '0;
            e.s = e.v ? gather_sel(s, off) : '0;
            check("busy", sif.busy, active);
            check("done", sif.done, active && rel == T);
            check("stage", sif.stage, active ? s : 0);
            check("rd_valid", sif.rd_valid, e.v);
            if (e.v) check("rd_addr", sif.rd_addr, e.a);
            check("sel_out", sif.sel_out_bus, e.s);
            check("wr_valid", sif.wr_valid, hist[0].v);
            if (hist[0].v) check("wr_addr", sif.wr_addr, hist[0].a);
            check("sel_in", sif.sel_in_bus, hist[0].s);
            if (sif.rd_valid) begin
                b = data_t'($urandom);
                for (int k = 0; k < N; k++)
                    p[k*8 +: 8] = b[int'(sif.sel_out_bus[k*SELW +: SELW])*8 +: 8];
                src_q.push_back(b);
                port_q.push_back(p);
            end
            if (sif.wr_valid) begin
                if (src_q.size() == 0) check("loop_empty", 1, 0);
                else begin
                    b = src_q.pop_front();
                    p = port_q.pop_front();
                    r = '0;
                    for (int k = 0; k < N; k++)
                        r[int'(sif.sel_in_bus[k*SELW +: SELW])*8 +: 8] = p[k*8 +: 8];
                    check("loopback", r, b);
                end
            end
            if (cyc == 2 || cyc == rst_until) rst = 0;
            sif.start = (cyc >= 150 && cyc < 200) ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (!did_rst && cyc > 300 && active && rel == 9) begin
                did_rst   = 1;
                rst_until = cyc + 2;
                #2 rst = 1;
                #1 zero_check("abort");
            end
            if (rst) begin
                active = 0;
                rel    = 0;
                hist.delete();
                repeat (LAT) hist.push_back('0);
                src_q.delete();
                port_q.delete();
            end else begin
                void'(hist.pop_front());
                hist.push_back(e);
                if (active) begin
                    if (rel == T) active = 0;
                    else rel++;
                end else if (sif.start) begin
                    active = 1;
                    rel    = 1;
                end
            end
        end
        check("abort_seen", did_rst, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
